// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM encoding and
// parameter legality check.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit chunk_legal(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_serial_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full adders.
// c_msb is the carry into the top bit, used for two's-complement overflow.
module rca_chunk
  import chunked_serial_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through one
// shared rca_chunk, rippling the carry between chunks in a register.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | one chunk added per cycle, idx_q selects the slice
// DONE  | single-cycle done pulse; a new start may chain straight into RUN
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OV
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_params
    $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q, busy_q, done_q, co_q, ov_q;
  logic [IDXW-1:0]  idx_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             co_chunk, cmsb_chunk;
  logic             last_chunk;

  always_comb begin
    a_chunk    = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk    = b_q[int'(idx_q)*CHUNK +: CHUNK];
    last_chunk = (idx_q == IDXW'(NCHUNK - 1));
  end

  rca_chunk #(.CHUNK(CHUNK)) u_rca (
    .a     (a_chunk),
    .b     (b_chunk),
    .ci    (carry_q),
    .s     (sum_chunk),
    .co    (co_chunk),
    .c_msb (cmsb_chunk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          // Subtraction becomes A + ~B + ~CI so the datapath only ever adds.
          if (start) begin
            a_q     <= A;
            b_q     <= SUB ? ~B : B;
            carry_q <= SUB ? ~CI : CI;
            idx_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[int'(idx_q)*CHUNK +: CHUNK] <= sum_chunk;
          carry_q <= co_chunk;
          idx_q   <= idx_q + IDXW'(1);
          if (last_chunk) begin
            co_q    <= co_chunk;
            ov_q    <= co_chunk ^ cmsb_chunk;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign CO   = co_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder (WIDTH=8, CHUNK=2), compared
// against an integer-arithmetic reference model.
module tb_chunked_serial_adder;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             SUB = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             CI = 1'b0;
  logic             busy, done, CO, OV;
  logic [WIDTH-1:0] S;

  int n_checks = 0;
  int n_fail   = 0;

  chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .SUB(SUB), .A(A), .B(B), .CI(CI),
    .busy(busy), .done(done), .S(S), .CO(CO), .OV(OV)
  );

  always #5 clk = ~clk;

  // Returns {ov, co, s}: exact signed/unsigned results checked for range.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sub);
    int ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    if (!sub) begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      co = (ur > 255);
    end else begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ur >= 0);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, co, ur[7:0]};
  endfunction

  // Called at a negedge; returns at the negedge sampling the done cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sub, input bit hold,
                       output logic [7:0] s_o, output logic co_o, output logic ov_o,
                       output int busy_n, output bit got);
    A = a; B = b; CI = ci; SUB = sub; start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    busy_n = 0; got = 1'b0;
    s_o = 'x; co_o = 1'bx; ov_o = 1'bx;
    for (int n = 0; n < 20 && !got; n++) begin
      if (done) begin
        got = 1'b1; s_o = S; co_o = CO; ov_o = OV;
      end else begin
        if (busy) busy_n++;
        A = 8'($urandom); B = 8'($urandom); CI = 1'($urandom); SUB = 1'($urandom);
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, S, CO, OV} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b S=%h CO=%b OV=%b, want all zero",
               busy, done, S, CO, OV);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va[8] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h05, 8'h07, 8'hFF};
    logic [7:0] vb[8] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h07, 8'h05, 8'hFF};
    logic       vc[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] want[8] = '{10'h010, 10'h100, 10'h100, 10'h280,
                            10'h37F, 10'h0FE, 10'h101, 10'h0FF};
    logic [7:0] s; logic co, ov; int bn; bit got;
    for (int i = 0; i < 8; i++) begin
      do_op(va[i], vb[i], vc[i], vs[i], 1'b0, s, co, ov, bn, got);
      n_checks++;
      if (!got || bn != NCHUNK) begin
        n_fail++;
        $display("FAIL directed_timing[%0d]: got_done=%0b busy_cycles=%0d, want 1 %0d",
                 i, got, bn, NCHUNK);
      end
      n_checks++;
      if ({ov, co, s} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: OV/CO/S=%b/%b/%h, want %b/%b/%h",
                 i, ov, co, s, want[i][9], want[i][8], want[i][7:0]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || {OV, CO, S} !== want[i]) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: done=%b OV/CO/S=%b/%b/%h, want 0 %b/%b/%h",
                 i, done, OV, CO, S, want[i][9], want[i][8], want[i][7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s; logic ci, sub, co, ov; logic [9:0] exp_v; int bn; bit got;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      exp_v = ref_op(a, b, ci, sub);
      do_op(a, b, ci, sub, 1'b0, s, co, ov, bn, got);
      n_checks++;
      if (!got || bn != NCHUNK || {ov, co, s} !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] a=%h b=%h ci=%b sub=%b: done=%0b busy=%0d OV/CO/S=%b/%b/%h, want %b/%b/%h",
                 i, a, b, ci, sub, got, bn, ov, co, s, exp_v[9], exp_v[8], exp_v[7:0]);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_held_start();
    logic [7:0] s; logic co, ov; logic [9:0] exp_v; int bn; bit got;
    exp_v = ref_op(8'h3C, 8'h5A, 1'b1, 1'b0);
    do_op(8'h3C, 8'h5A, 1'b1, 1'b0, 1'b1, s, co, ov, bn, got);
    n_checks++;
    if (!got || bn != NCHUNK || {ov, co, s} !== exp_v) begin
      n_fail++;
      $display("FAIL held_start: done=%0b busy=%0d OV/CO/S=%b/%b/%h, want 1 %0d %b/%b/%h",
               got, bn, ov, co, s, NCHUNK, exp_v[9], exp_v[8], exp_v[7:0]);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s; logic co, ov; logic [9:0] e1, e2; int bn, gap; bit got, first_busy;
    e1 = ref_op(8'hC3, 8'h4E, 1'b0, 1'b1);
    e2 = ref_op(8'h69, 8'h97, 1'b1, 1'b0);
    do_op(8'hC3, 8'h4E, 1'b0, 1'b1, 1'b0, s, co, ov, bn, got);
    n_checks++;
    if (!got || {ov, co, s} !== e1) begin
      n_fail++;
      $display("FAIL b2b_first: done=%0b OV/CO/S=%b/%b/%h, want %b/%b/%h",
               got, ov, co, s, e1[9], e1[8], e1[7:0]);
    end
    A = 8'h69; B = 8'h97; CI = 1'b1; SUB = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    first_busy = busy;
    gap = 1; got = 1'b0;
    while (gap < 20 && !got) begin
      if (done) got = 1'b1;
      else begin gap++; @(negedge clk); end
    end
    n_checks++;
    if (first_busy !== 1'b1 || !got || gap != NCHUNK + 1) begin
      n_fail++;
      $display("FAIL b2b_spacing: busy_next=%b done=%0b gap=%0d, want 1 1 %0d",
               first_busy, got, gap, NCHUNK + 1);
    end
    n_checks++;
    if ({OV, CO, S} !== e2) begin
      n_fail++;
      $display("FAIL b2b_second: OV/CO/S=%b/%b/%h, want %b/%b/%h",
               OV, CO, S, e2[9], e2[8], e2[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] s; logic co, ov; logic [9:0] exp_v; int bn; bit got, seen;
    do_op(8'h80, 8'hFF, 1'b0, 1'b0, 1'b0, s, co, ov, bn, got);
    @(negedge clk);
    A = 8'hAB; B = 8'h11; CI = 1'b1; SUB = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, S, CO, OV} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_state: busy=%b done=%b S=%h CO=%b OV=%b, want all zero",
               busy, done, S, CO, OV);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: activity seen=%b after reset, want 0", seen);
    end
    exp_v = ref_op(8'h5D, 8'hE2, 1'b0, 1'b1);
    do_op(8'h5D, 8'hE2, 1'b0, 1'b1, 1'b0, s, co, ov, bn, got);
    n_checks++;
    if (!got || bn != NCHUNK || {ov, co, s} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_mid_recover: done=%0b busy=%0d OV/CO/S=%b/%b/%h, want %b/%b/%h",
               got, bn, ov, co, s, exp_v[9], exp_v[8], exp_v[7:0]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_held_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's fixed-width 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry between chunks through a register.
- Trades latency for area in wide datapaths.
- Start/busy/done handshake; adds signed overflow and a subtract mode.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when ready.
- SUB  in  1  0: A+B+CI; 1: A-B-CI, computed as A + ~B + ~CI.
- A  in  WIDTH  operand A; captured on accepted start.
- B  in  WIDTH  operand B; captured on accepted start.
- CI  in  1  carry-in (borrow-in when SUB=1); captured on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when results are valid.
- S  out  WIDTH  sum/difference.
- CO  out  1  raw carry-out of the final chunk (for SUB: 1 = no borrow).
- OV  out  1  two's-complement overflow.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, S=0, CO=0, OV=0; operand, carry and chunk-index registers cleared.
- rst has priority over all other inputs, including in the middle of an operation. The current operation is abandoned, and no done pulse is produced for it.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1, capture A, B (B inverted if SUB), and carry = CI (or ~CI if SUB). Clear idx and S. Go to RUN.
  - RUN: each cycle add chunk idx (bits idx*CHUNK +: CHUNK) of the captured operands with the carry register. Write that slice of S, update the carry, idx++. When idx == NCHUNK-1, go to DONE.
  - DONE: done=1 for exactly this cycle. CO = final carry. OV = carry into MSB XOR carry out of MSB. Then return to IDLE, or go straight to RUN if start=1, with the same capture as in IDLE.
- ready is defined as state ∈ {IDLE, DONE}. start is ignored in RUN.
- Timing: start accepted at edge t0 → busy=1 for cycles t0+1 … t0+NCHUNK; done=1 in cycle t0+NCHUNK+1.
- Latency is NCHUNK+1 cycles from the start edge to done. Throughput is one operation per NCHUNK+1 cycles.
- S, CO and OV hold their values after done until the next accepted start. The slices of S are cleared on capture, so S is undefined-free during RUN.
- Input changes on A, B, CI and SUB after capture have no effect.
- CHUNK=WIDTH degenerates to NCHUNK=1: one RUN cycle.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package contains:
  - FSM state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - A WIDTH % CHUNK legality check macro/function used by an elaboration-time assertion.
- One sub-module, rca_chunk #(CHUNK):
  - Purely combinational CHUNK-bit ripple-carry adder built from full adders.
  - Ports: a, b, ci, s, co, plus c_msb (carry into its MSB, used for OV).
  - Instantiated once; the top module muxes the operand slices into it.

Test Plan (WIDTH=8, CHUNK=2, NCHUNK=4):
- Basic add: A=8'h0F, B=8'h01, CI=0, SUB=0, start pulse → busy 4 cycles; done in the 5th cycle; S=8'h10, CO=0, OV=0.
- Unsigned carry-out: A=8'hFF, B=8'h01, CI=0 → S=8'h00, CO=1, OV=0. Also A=8'hFF, B=8'h00, CI=1 → S=8'h00, CO=1.
- Signed overflow: A=8'h7F, B=8'h01, CI=0 → S=8'h80, CO=0, OV=1. Also A=8'h80, B=8'hFF → S=8'h7F, CO=1, OV=1.
- Subtract: SUB=1, A=8'h05, B=8'h07, CI=0 → S=8'hFE, CO=0 (borrow), OV=0. Also SUB=1, A=8'h07, B=8'h05, CI=1 → S=8'h01, CO=1.
- Handshake:
  - start held high through RUN with changing A/B → only the first operation is computed; the result is unchanged.
  - start asserted in the DONE cycle → second operation begins with no idle cycle; done pulses are exactly NCHUNK+1 cycles apart.
- Reset mid-operation: rst=1 during the 2nd RUN cycle → next cycle busy=0, done=0, S=0, CO=0, OV=0. No done pulse follows. A new start after reset completes correctly.
